// File: rtl/avalon_ram_slave.sv
// Avalon-MM responder RAM with programmable wait states, byte-enabled writes
// and a side-band preload port for loading program images.
//
//   state | meaning
//   IDLE  | no transaction; waiting for read/write (stalled while preloading)
//   WAIT  | counting down wait states for the pending request
//   ACK   | waitrequest low; transaction commits on the closing edge
module avalon_ram_slave #(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        write,
   input  logic        read,
   output logic        waitrequest,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   input  logic        preload_en,
   input  logic [7:0]  preload_addr,
   input  logic [31:0] preload_data,
   output logic        bus_error
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t                 state, state_nx;
   logic [3:0]             cnt, cnt_nx;
   logic                   enter_ack;
   logic                   op_write;
   logic [31:0]            mem [DEPTH];
   logic [ADDR_BITS-1:0]   bus_idx;
   logic [ADDR_BITS-1:0]   pre_idx;
   logic [31:0]            pre_ext;
   logic                   unused_bits;

   assign bus_idx     = address[ADDR_BITS+1:2];
   assign pre_ext     = {24'd0, preload_addr};
   assign pre_idx     = pre_ext[ADDR_BITS+1:2];
   assign unused_bits = ^{address[31:ADDR_BITS+2], address[1:0], pre_ext};

   assign waitrequest = (state != ST_ACK);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      enter_ack = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!preload_en && (read || write)) begin
               cnt_nx = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES > 0) begin
                  state_nx = ST_WAIT;
               end else begin
                  state_nx  = ST_ACK;
                  enter_ack = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (preload_en || !(read || write)) begin
               state_nx = ST_IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt <= 4'd1) begin
               state_nx  = ST_ACK;
               cnt_nx    = 4'd0;
               enter_ack = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ST_ACK: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         op_write  <= 1'b0;
         readdata  <= 32'd0;
         bus_error <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (read && write) begin
            bus_error <= 1'b1;
         end
         // A read+write conflict resolves as a write, so readdata is left alone.
         if (enter_ack) begin
            op_write <= write;
            if (!write) begin
               readdata <= mem[bus_idx];
            end
         end
         // The master saw waitrequest low in ACK, so the write must land even
         // if the request or preload changes during that cycle.
         if (state == ST_ACK && op_write) begin
            for (int b = 0; b < 4; b++) begin
               if (byteenable[b]) begin
                  mem[bus_idx][8*b +: 8] <= writedata[8*b +: 8];
               end
            end
         end
         // Placed last so a preload to the same word wins over the bus write.
         if (preload_en) begin
            mem[pre_idx] <= preload_data;
         end
      end
   end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: three instances (0, 1 and 3 wait states) checked
// against a word-array reference model with directed and random transactions.
module tb_avalon_ram_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        preload_en;
   logic [7:0]  preload_addr;
   logic [31:0] preload_data;
   logic [2:0]  rd, wr, wreq, berr;
   logic [31:0] rdata [3];

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] model  [3][256];
   logic [31:0] exp_rd [3];
   logic        exp_err[3];

   always #5 clk = ~clk;

   avalon_ram_slave #(.ADDR_BITS(8), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .address(address), .write(wr[0]), .read(rd[0]),
      .waitrequest(wreq[0]), .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[0]), .preload_en(preload_en), .preload_addr(preload_addr),
      .preload_data(preload_data), .bus_error(berr[0]));

   avalon_ram_slave #(.ADDR_BITS(8), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset), .address(address), .write(wr[1]), .read(rd[1]),
      .waitrequest(wreq[1]), .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[1]), .preload_en(preload_en), .preload_addr(preload_addr),
      .preload_data(preload_data), .bus_error(berr[1]));

   avalon_ram_slave #(.ADDR_BITS(8), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset), .address(address), .write(wr[2]), .read(rd[2]),
      .waitrequest(wreq[2]), .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[2]), .preload_en(preload_en), .preload_addr(preload_addr),
      .preload_data(preload_data), .bus_error(berr[2]));

   function automatic int wc(input int k);
      return (k == 0) ? 0 : (k == 1) ? 1 : 3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 256; i++) model[k][i] = 32'd0;
         exp_rd[k]  = 32'd0;
         exp_err[k] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      rd = '0; wr = '0; preload_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();
      for (int k = 0; k < 3; k++) begin
         chk("reset_waitrequest", 32'(wreq[k]), 32'd1);
         chk("reset_readdata", rdata[k], 32'd0);
         chk("reset_bus_error", 32'(berr[k]), 32'd0);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      preload_en = 1'b1; preload_addr = a; preload_data = d;
      @(posedge clk); #1;
      preload_en = 1'b0;
      for (int k = 0; k < 3; k++) model[k][a >> 2] = d;
   endtask

   task automatic bus_xfer(input int k, input bit do_rd, input bit do_wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int lat;
      int idx;
      logic [31:0] got;
      lat = -1;
      got = 32'd0;
      @(posedge clk); #1;
      address = a; writedata = d; byteenable = be;
      rd[k] = do_rd; wr[k] = do_wr;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!wreq[k]) begin
            lat = c;
            got = rdata[k];
            break;
         end
      end
      @(posedge clk); #1;
      rd[k] = 1'b0; wr[k] = 1'b0;
      chk("latency", 32'(lat), 32'(1 + wc(k)));
      idx = int'((a >> 2) & 32'd255);
      if (do_wr) begin
         model[k][idx] = merge(model[k][idx], d, be);
         if (do_rd) exp_err[k] = 1'b1;
      end else if (do_rd) begin
         exp_rd[k] = model[k][idx];
      end
      chk("readdata", got, exp_rd[k]);
      chk("bus_error", 32'(berr[k]), 32'(exp_err[k]));
   endtask

   initial begin
      int lat;
      reset = 1'b1; address = '0; writedata = '0; byteenable = '0;
      preload_en = 1'b0; preload_addr = '0; preload_data = '0;
      rd = '0; wr = '0;
      clear_model();

      do_reset();
      bus_xfer(1, 1, 0, 32'h04, 32'h0, 4'h0);

      preload(8'h04, 32'h2404FFFF);
      preload(8'h10, 32'h00000008);
      bus_xfer(1, 1, 0, 32'h04, 32'h0, 4'h0);
      chk("preload_word_04", exp_rd[1], 32'h2404FFFF);
      bus_xfer(1, 1, 0, 32'h10, 32'h0, 4'h0);

      preload(8'h08, 32'h11223344);
      bus_xfer(1, 0, 1, 32'h08, 32'hAABBCCDD, 4'b0101);
      bus_xfer(1, 1, 0, 32'h08, 32'h0, 4'h0);
      chk("byteenable_merge", exp_rd[1], 32'h11BB33DD);
      bus_xfer(1, 0, 1, 32'h08, 32'hFFFFFFFF, 4'b0000);
      bus_xfer(1, 1, 0, 32'h08, 32'h0, 4'h0);

      bus_xfer(0, 0, 1, 32'h00000404, 32'hDEADBEEF, 4'hF);
      bus_xfer(0, 1, 0, 32'h04, 32'h0, 4'h0);

      // Write dropped mid-WAIT must leave the word untouched.
      preload(8'h24, 32'h0BADC0DE);
      @(posedge clk); #1;
      address = 32'h24; writedata = 32'h99999999; byteenable = 4'hF; wr[2] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("drop_waitrequest", 32'(wreq[2]), 32'd1);
      wr[2] = 1'b0;
      bus_xfer(2, 1, 0, 32'h24, 32'h0, 4'h0);

      // Reset during WAIT aborts the write and clears memory.
      @(posedge clk); #1;
      address = 32'h20; writedata = 32'hCAFEF00D; byteenable = 4'hF; wr[2] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; wr[2] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      clear_model();
      chk("rst_wait_waitrequest", 32'(wreq[2]), 32'd1);
      bus_xfer(2, 1, 0, 32'h20, 32'h0, 4'h0);
      bus_xfer(2, 1, 0, 32'h24, 32'h0, 4'h0);

      // Preload during WAIT restarts the transaction once preload_en falls.
      @(posedge clk); #1;
      address = 32'h28; writedata = 32'h55AA55AA; byteenable = 4'hF; wr[2] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      preload_en = 1'b1; preload_addr = 8'h2C; preload_data = 32'h00000077;
      @(posedge clk); @(posedge clk); #1;
      preload_en = 1'b0;
      for (int k = 0; k < 3; k++) model[k][8'h2C >> 2] = 32'h00000077;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!wreq[2]) begin
            lat = c;
            break;
         end
      end
      @(posedge clk); #1;
      wr[2] = 1'b0;
      model[2][8'h28 >> 2] = 32'h55AA55AA;
      chk("preload_restart_latency", 32'(lat), 32'd4);
      bus_xfer(2, 1, 0, 32'h28, 32'h0, 4'h0);
      bus_xfer(2, 1, 0, 32'h2C, 32'h0, 4'h0);

      // Read+write conflict resolves as a write and latches bus_error.
      bus_xfer(1, 1, 1, 32'h0C, 32'h12345678, 4'hF);
      bus_xfer(1, 1, 0, 32'h0C, 32'h0, 4'h0);
      chk("conflict_written", exp_rd[1], 32'h12345678);

      for (int i = 0; i < 60; i++) begin
         int k;
         int op;
         k  = int'($urandom_range(0, 2));
         op = int'($urandom_range(0, 3));
         if (op == 0)
            preload(8'($urandom()), $urandom());
         else if (op == 1)
            bus_xfer(k, 0, 1, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
         else
            bus_xfer(k, 1, 0, $urandom(), 32'h0, 4'h0);
      end

      do_reset();
      bus_xfer(1, 1, 0, 32'h0C, 32'h0, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/avalon_ram_slave.md
Name: avalon_ram_slave

Overview:
- Avalon memory-mapped slave (responder) memory: the far end of the CPU's bus master interface.
- Serves word reads and byte-enabled writes with a configurable number of wait states, signalled via waitrequest.
- Provides a side-band preload port so testbenches can load instruction words before or while the CPU runs.
- Sits beside the top-level CPU in every testbench and replaces ad-hoc RAM models.

Parameters:
- ADDR_BITS, 8: word-index width; depth = 2**ADDR_BITS 32-bit words.
- WAIT_CYCLES, 1: extra stall cycles before a transaction completes (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- address  input  32  byte address; word index = address[ADDR_BITS+1:2]; bits [1:0] and the bits above the index are ignored, so addresses alias.
- write  input  1  write request.
- read  input  1  read request.
- waitrequest  output  1  high = slave not accepting; a transaction completes on the edge where it is low.
- writedata  input  32  write data.
- byteenable  input  4  lane enables; bit n controls byte [8n+7:8n].
- readdata  output  32  read data; valid while waitrequest is low for a read.
- preload_en  input  1  preload write enable.
- preload_addr  input  8  preload byte address; word index = preload_addr[ADDR_BITS+1:2].
- preload_data  input  32  full word to preload.
- bus_error  output  1  sticky flag: read and write were both asserted in one cycle.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FSM goes to IDLE and the counter clears.
  - readdata=0, bus_error=0, waitrequest=1.
  - All memory words clear to 0.
  - An in-flight transaction is aborted and no write is committed.
- waitrequest = 1 in every state except ACK.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if preload_en=1, stay in IDLE. Otherwise, if read or write is asserted, load cnt=WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else go to ACK.
  - WAIT: if the request has dropped, go to IDLE with no effect. Else decrement cnt; when cnt reaches 1, go to ACK on this edge.
  - ACK: waitrequest=0. At the end of the cycle the transaction commits, then the state returns to IDLE unconditionally. Back-to-back requests therefore see a minimum of 1+WAIT_CYCLES stall cycles each.
- Read path: on the edge entering ACK, register readdata <= mem[word index of the current address]. readdata holds this value until the next read enters ACK.
- Write path: on the ACK-cycle edge, update only the enabled bytes of mem[index] from writedata. byteenable=0000 performs no update but still completes.
- Completion latency: a request asserted in cycle 0 completes at the end of cycle 1+WAIT_CYCLES.
- The master holds address, writedata and byteenable stable while waitrequest=1. The slave samples them in the cycle it acts on them; it does not latch them at request time.
- read and write both asserted:
  - The transaction is treated as a write and readdata is unchanged.
  - bus_error is set to 1 and stays set until reset.
- Preload:
  - Every rising edge with preload_en=1 writes preload_data to the full word at the preload index.
  - The FSM is held in or entered to IDLE (an in-flight transaction is aborted), so bus requests stall while preloading.
  - Preload has priority over a bus write to the same word.
- Request dropped while in ACK: the commit still happens; the master is responsible for holding the request.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → waitrequest=1, readdata=0, bus_error=0; a read of 0x04 returns 0x00000000.
- Preload and read, WAIT_CYCLES=1: preload 0x04=0x2404FFFF, 0x10=0x00000008; read 0x04 asserted at cycle 0 → waitrequest low only in cycle 2, readdata=0x2404FFFF. Read 0x10 → 0x00000008.
- Byte-enable write: word 0x08=0x11223344; write 0xAABBCCDD with byteenable=0101 → read returns 0x11BB33DD.
- Aliasing and wait states: WAIT_CYCLES=0, write 0xDEADBEEF to 0x00000404 (ADDR_BITS=8) → read of 0x04 returns 0xDEADBEEF, with waitrequest low in cycle 1.
- Abort cases:
  - Assert write, drop it during WAIT (WAIT_CYCLES=3) → memory unchanged.
  - Assert write, pull reset low in WAIT → memory 0, state IDLE.
  - Preload during WAIT → transaction restarts and completes after preload_en falls.
- Conflict: assert read=1 and write=1 to 0x0C with data 0x12345678 → word written, readdata unchanged, bus_error=1 until reset.
